// File: rtl/sevenseg_if.sv
// Observed multiplexed seven-segment display bus: active-low anodes and segments.
// The display driver (or bench) is the master; the capture block listens as slave.
interface sevenseg_if;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (output an, output seg);
  modport slave  (input an, input seg);
endinterface

// File: rtl/sevenseg_capture.sv
// Reader for the multiplexed seven-segment bus: settles each refresh slot, decodes the
// segment pattern back to hex and publishes the 4-digit word once all slots are seen.
module sevenseg_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  sevenseg_if.slave   bus,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        frame_valid,
  output logic        code_err,
  output logic        link_up
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_CYCLES);

  // Bit 4 is the valid flag, bits 3:0 the decoded hex value.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h40:   res = 5'h10;
      7'h79:   res = 5'h11;
      7'h24:   res = 5'h12;
      7'h30:   res = 5'h13;
      7'h19:   res = 5'h14;
      7'h12:   res = 5'h15;
      7'h02:   res = 5'h16;
      7'h78:   res = 5'h17;
      7'h00:   res = 5'h18;
      7'h10:   res = 5'h19;
      7'h08:   res = 5'h1A;
      7'h03:   res = 5'h1B;
      7'h46:   res = 5'h1C;
      7'h21:   res = 5'h1D;
      7'h06:   res = 5'h1E;
      7'h0E:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [10:0]   sync1_r, sync2_r;
  logic [SW-1:0] stable_cnt_r;
  logic          sampled_r;
  logic [3:0]    seen_r;
  logic [IW-1:0] idle_r;
  logic [3:0]    scratch_r [4];

  logic          changed_s, onehot_s, sample_s;
  logic [1:0]    slot_s;
  logic [4:0]    dec_s;
  logic [3:0]    seen_next_s;
  logic [3:0]    frame_s [4];

  // Slot selection, decode and the word as it would look with the current sample merged in.
  always_comb begin
    changed_s = (sync1_r != sync2_r);
    onehot_s  = 1'b1;
    slot_s    = 2'd0;
    case (sync2_r[10:7])
      4'b1110: slot_s = 2'd0;
      4'b1101: slot_s = 2'd1;
      4'b1011: slot_s = 2'd2;
      4'b0111: slot_s = 2'd3;
      default: onehot_s = 1'b0;
    endcase
    dec_s       = decode_seg(sync2_r[6:0]);
    sample_s    = (stable_cnt_r == SETTLE_MAX) && !sampled_r && onehot_s;
    seen_next_s = seen_r | (4'b0001 << slot_s);
    for (int i = 0; i < 4; i++) begin
      if (slot_s == 2'(i)) begin
        frame_s[i] = dec_s[3:0];
      end else begin
        frame_s[i] = scratch_r[i];
      end
    end
  end

  // The counter tracks the value S is about to take, so it always describes the current S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r      <= 11'd0;
      sync2_r      <= 11'd0;
      stable_cnt_r <= '0;
      sampled_r    <= 1'b0;
    end else begin
      sync1_r <= {bus.an, bus.seg};
      sync2_r <= sync1_r;
      if (changed_s) begin
        stable_cnt_r <= '0;
        sampled_r    <= 1'b0;
      end else begin
        if (stable_cnt_r != SETTLE_MAX) begin
          stable_cnt_r <= stable_cnt_r + SW'(1);
        end
        if (sample_s) begin
          sampled_r <= 1'b1;
        end
      end
    end
  end

  // Frame assembly, error reporting and link supervision; a sample always beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_r      <= 4'd0;
      idle_r      <= '0;
      scratch_r   <= '{4'd0, 4'd0, 4'd0, 4'd0};
      ones        <= 4'd0;
      tens        <= 4'd0;
      hundreds    <= 4'd0;
      thousands   <= 4'd0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      if (sample_s) begin
        idle_r <= '0;
        if (dec_s[4]) begin
          scratch_r[slot_s] <= dec_s[3:0];
          if (seen_next_s == 4'b1111) begin
            ones        <= frame_s[0];
            tens        <= frame_s[1];
            hundreds    <= frame_s[2];
            thousands   <= frame_s[3];
            frame_valid <= 1'b1;
            link_up     <= 1'b1;
            seen_r      <= 4'd0;
          end else begin
            seen_r <= seen_next_s;
          end
        end else begin
          code_err <= 1'b1;
          seen_r   <= 4'd0;
        end
      end else if (idle_r == IDLE_MAX) begin
        link_up <= 1'b0;
        seen_r  <= 4'd0;
      end else begin
        idle_r <= idle_r + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: drives refresh sequences on the display bus and
// checks published words against a scoreboard of expected frames.
module tb_sevenseg_capture;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 3000;

  logic       clk;
  logic       rst;
  logic [3:0] ones, tens, hundreds, thousands;
  logic       frame_valid, code_err, link_up;

  sevenseg_if bus ();

  sevenseg_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .frame_valid(frame_valid), .code_err(code_err), .link_up(link_up)
  );

  logic [6:0]  enc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] sb [$];
  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int ce_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every published frame must match the oldest pending expectation.
  always @(negedge clk) begin
    if (code_err) ce_cnt++;
    if (frame_valid) begin
      fv_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_frame", {thousands, hundreds, tens, ones}, 32'hFFFF_FFFF);
      end else begin
        chk("frame_word", {thousands, hundreds, tens, ones}, sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_slot(input int idx, input logic [6:0] s, input int len, input bit glitch);
    bus.an = 4'(~(4'b0001 << idx));
    for (int c = 0; c < len; c++) begin
      if (glitch && c < 5) bus.seg = s ^ 7'($urandom_range(1, 127));
      else                 bus.seg = s;
      @(posedge clk);
    end
  endtask

  task automatic refresh(input logic [15:0] d, input int len, input bit glitch);
    sb.push_back(d);
    for (int i = 0; i < 4; i++) drive_slot(i, enc_tab[d[4*i +: 4]], len, glitch);
  endtask

  initial begin
    logic [15:0] d;
    rst    = 1'b1;
    bus.an = 4'hF;
    bus.seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", {thousands, hundreds, tens, ones}, 32'h0);
    chk("reset_flags", {frame_valid, code_err, link_up}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Slow clean mux, 1000-cycle slots.
    refresh(16'h4321, 1000, 1'b0);
    refresh(16'h4321, 1000, 1'b0);
    #1;
    chk("clean_frames", fv_cnt, 2);
    chk("clean_link", link_up, 1);
    chk("clean_digits", {thousands, hundreds, tens, ones}, 32'h4321);

    // Segment glitches at each slot start.
    refresh(16'h4321, 200, 1'b1);
    refresh(16'h9E0B, 200, 1'b1);
    #1;
    chk("glitch_frames", fv_cnt, 4);
    chk("no_code_err", ce_cnt, 0);

    // All sixteen codes visit every digit position.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'((k + 4 * i) % 16);
      refresh(d, 40, 1'b0);
    end
    #1;
    chk("hex_frames", fv_cnt, 20);

    // Blank tens slot discards the frame.
    drive_slot(0, enc_tab[1], 200, 1'b0);
    drive_slot(1, 7'h7F, 200, 1'b0);
    drive_slot(2, enc_tab[3], 200, 1'b0);
    drive_slot(3, enc_tab[4], 200, 1'b0);
    #1;
    chk("blank_code_err", ce_cnt, 1);
    chk("blank_no_frame", fv_cnt, 20);
    refresh(16'h4321, 200, 1'b0);
    #1;
    chk("recover_frame", fv_cnt, 21);

    // Idle bus: last sample landed ~180 cycles before the hold started.
    bus.an = 4'hF;
    bus.seg = 7'h7F;
    repeat (TIMEOUT - 195) @(posedge clk);
    #1;
    chk("link_before_timeout", link_up, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("link_after_timeout", link_up, 0);
    repeat (175) @(posedge clk);
    #1;
    chk("timeout_digits_hold", {thousands, hundreds, tens, ones}, 32'h4321);
    refresh(16'h8765, 200, 1'b0);
    #1;
    chk("link_restored", link_up, 1);
    chk("restored_frames", fv_cnt, 22);

    // Reset mid-frame: the two captured slots must be forgotten.
    drive_slot(0, enc_tab[9], 200, 1'b0);
    drive_slot(1, enc_tab[8], 200, 1'b0);
    bus.an = 4'hF;
    @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_outputs", {thousands, hundreds, tens, ones, 3'b000, link_up}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(16'h5678);
    drive_slot(2, enc_tab[6], 200, 1'b0);
    drive_slot(3, enc_tab[5], 200, 1'b0);
    #1;
    chk("partial_no_frame", fv_cnt, 22);
    chk("partial_outputs_zero", {thousands, hundreds, tens, ones}, 32'h0);
    drive_slot(0, enc_tab[8], 200, 1'b0);
    drive_slot(1, enc_tab[7], 200, 1'b0);
    #1;
    chk("reset_recapture", fv_cnt, 23);
    chk("final_code_err", ce_cnt, 1);
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
